// File: rtl/palindrome_pkg.sv
// Shared defaults and width helpers for the palindrome detector.
package palindrome_pkg;

   localparam int unsigned DEF_DATA_WIDTH   = 8;
   localparam int unsigned DEF_SYMBOL_WIDTH = 1;
   localparam int unsigned DEF_COUNT_WIDTH  = 16;

   // Width able to hold 0..n_symbols/2 mismatching pairs, never below 1.
   function automatic int unsigned mismatch_width(input int unsigned n_symbols);
      int unsigned w;
      w = $clog2(n_symbols / 2 + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Per-pair vector width; a single-symbol word still gets a 1-bit vector.
   function automatic int unsigned pair_vec_width(input int unsigned n_symbols);
      return (n_symbols / 2 > 0) ? n_symbols / 2 : 1;
   endfunction

endpackage

// File: rtl/palindrome_compare.sv
// Combinational mirror compare: per-pair mismatch flags, their popcount and a match flag.
module palindrome_compare
   import palindrome_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned SYMBOL_WIDTH = DEF_SYMBOL_WIDTH
) (
   input  logic [DATA_WIDTH-1:0]                                          i_data,
   output logic [pair_vec_width(DATA_WIDTH/SYMBOL_WIDTH)-1:0]             o_pair_mismatch,
   output logic [mismatch_width(DATA_WIDTH/SYMBOL_WIDTH)-1:0]             o_mismatch_pairs,
   output logic                                                           o_match
);

   localparam int unsigned N_SYM   = DATA_WIDTH / SYMBOL_WIDTH;
   localparam int unsigned N_PAIRS = N_SYM / 2;
   localparam int unsigned PV_W    = pair_vec_width(N_SYM);
   localparam int unsigned MM_W    = mismatch_width(N_SYM);

   logic [PV_W-1:0] w_pair_mismatch;
   logic [MM_W-1:0] w_mismatch_pairs;

   // Symbols are compared whole; the middle symbol of an odd N is never visited.
   always_comb begin
      w_pair_mismatch = '0;
      for (int unsigned i = 0; i < N_PAIRS; i++) begin
         w_pair_mismatch[i] = (i_data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] !=
                               i_data[(N_SYM-1-i)*SYMBOL_WIDTH +: SYMBOL_WIDTH]);
      end
   end

   always_comb begin
      w_mismatch_pairs = '0;
      for (int unsigned i = 0; i < N_PAIRS; i++) begin
         w_mismatch_pairs = w_mismatch_pairs + MM_W'(w_pair_mismatch[i]);
      end
   end

   assign o_pair_mismatch  = w_pair_mismatch;
   assign o_mismatch_pairs = w_mismatch_pairs;
   assign o_match          = (w_mismatch_pairs == '0);

endmodule

// File: rtl/palindrome.sv
// One-cycle registered palindrome checker with a saturating palindrome counter.
module palindrome
   import palindrome_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned SYMBOL_WIDTH = DEF_SYMBOL_WIDTH,
   parameter int unsigned COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               in_valid,
   input  logic [DATA_WIDTH-1:0]                              data_in,
   input  logic                                               clear_count,
   output logic                                               out_valid,
   output logic                                               detection,
   output logic [mismatch_width(DATA_WIDTH/SYMBOL_WIDTH)-1:0] mismatch_pairs,
   output logic [COUNT_WIDTH-1:0]                             pal_count
);

   localparam int unsigned N_SYM = DATA_WIDTH / SYMBOL_WIDTH;
   localparam int unsigned PV_W  = pair_vec_width(N_SYM);
   localparam int unsigned MM_W  = mismatch_width(N_SYM);

   if (SYMBOL_WIDTH < 1 || DATA_WIDTH < 1 || (DATA_WIDTH % SYMBOL_WIDTH) != 0) begin : g_bad_params
      $error("palindrome: DATA_WIDTH must be a non-zero multiple of SYMBOL_WIDTH");
   end

   logic [PV_W-1:0]        w_pair_mismatch;
   logic [MM_W-1:0]        w_mismatch_pairs;
   logic                   w_match;
   logic                   w_detect;

   logic                   r_out_valid;
   logic                   r_detection;
   logic [MM_W-1:0]        r_mismatch_pairs;
   logic [COUNT_WIDTH-1:0] r_pal_count;

   palindrome_compare #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SYMBOL_WIDTH (SYMBOL_WIDTH)
   ) u_compare (
      .i_data           (data_in),
      .o_pair_mismatch  (w_pair_mismatch),
      .o_mismatch_pairs (w_mismatch_pairs),
      .o_match          (w_match)
   );

   assign w_detect = ~|w_pair_mismatch;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid      <= 1'b0;
         r_detection      <= 1'b0;
         r_mismatch_pairs <= '0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_detection      <= w_detect;
            r_mismatch_pairs <= w_mismatch_pairs;
         end
      end
   end

   // Clear wins over the old value but not over the word accepted in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pal_count <= '0;
      end else if (clear_count) begin
         r_pal_count <= (in_valid && w_match) ? COUNT_WIDTH'(1) : '0;
      end else if (in_valid && w_match && (r_pal_count != '1)) begin
         r_pal_count <= r_pal_count + COUNT_WIDTH'(1);
      end
   end

   assign out_valid      = r_out_valid;
   assign detection      = r_detection;
   assign mismatch_pairs = r_mismatch_pairs;
   assign pal_count      = r_pal_count;

endmodule

// File: tb/tb_palindrome.sv
// Bench for palindrome: three parameterisations driven in lockstep against a behavioural model.
module tb_palindrome;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] data_in = '0;
   logic       clear_count = 1'b0;

   // Default: 8 one-bit symbols, 16-bit counter.
   logic        v0, d0;
   logic [2:0]  m0;
   logic [15:0] c0;
   // Nibble symbols.
   logic        v4, d4;
   logic [0:0]  m4;
   logic [15:0] c4;
   // 2-bit saturating counter.
   logic        vc, dc;
   logic [2:0]  mc;
   logic [1:0]  cc;

   always #5 clk = ~clk;

   palindrome dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clear_count(clear_count),
      .out_valid(v0), .detection(d0), .mismatch_pairs(m0), .pal_count(c0));

   palindrome #(.SYMBOL_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clear_count(clear_count),
      .out_valid(v4), .detection(d4), .mismatch_pairs(m4), .pal_count(c4));

   palindrome #(.COUNT_WIDTH(2)) dutc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clear_count(clear_count),
      .out_valid(vc), .detection(dc), .mismatch_pairs(mc), .pal_count(cc));

   typedef struct {
      logic       v;
      logic       d0; int m0; int c0;
      logic       d4; int m4; int c4;
      logic       dc; int mc; int cc;
   } exp_t;

   typedef struct {
      logic       rst, iv, clr;
      logic [7:0] data;
      logic       exp_det;
      int         exp_mm;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Model state.
   logic md0 = 0, md4 = 0, mdc = 0;
   int   mm0 = 0, mm4 = 0, mmc = 0, mc0 = 0, mc4 = 0, mcc = 0;

   function automatic int mm_count(input logic [7:0] d, input int sw);
      int n, cnt;
      logic [7:0] a, b, mask;
      n = 8 / sw;
      cnt = 0;
      mask = 8'((1 << sw) - 1);
      for (int i = 0; i < n / 2; i++) begin
         a = d >> (i * sw);
         b = d >> ((n - 1 - i) * sw);
         if (((a ^ b) & mask) != 0) cnt++;
      end
      return cnt;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_one(input logic r, input logic iv, input logic clr, input int mm,
                            input int maxc, inout logic d, inout int m, inout int c);
      if (r) begin
         d = 0; m = 0; c = 0;
      end else begin
         if (iv) begin d = (mm == 0); m = mm; end
         if (clr) c = 0;
         if (iv && mm == 0 && c < maxc) c++;
      end
   endtask

   task automatic step(input logic r, input logic iv, input logic clr, input logic [7:0] d);
      exp_t e, got;
      int   mb, mn;
      @(negedge clk);
      rst = r; in_valid = iv; clear_count = clr; data_in = d;
      mb = mm_count(d, 1);
      mn = mm_count(d, 4);
      model_one(r, iv, clr, mb, 65535, md0, mm0, mc0);
      model_one(r, iv, clr, mn, 65535, md4, mm4, mc4);
      model_one(r, iv, clr, mb, 3,     mdc, mmc, mcc);
      e.v  = iv & ~r;
      e.d0 = md0; e.m0 = mm0; e.c0 = mc0;
      e.d4 = md4; e.m4 = mm4; e.c4 = mc4;
      e.dc = mdc; e.mc = mmc; e.cc = mcc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("out_valid",       32'(v0), 32'(got.v));
      check("detection",       32'(d0), 32'(got.d0));
      check("mismatch_pairs",  32'(m0), 32'(got.m0));
      check("pal_count",       32'(c0), 32'(got.c0));
      check("sym4_out_valid",  32'(v4), 32'(got.v));
      check("sym4_detection",  32'(d4), 32'(got.d4));
      check("sym4_mismatch",   32'(m4), 32'(got.m4));
      check("sym4_pal_count",  32'(c4), 32'(got.c4));
      check("cw2_out_valid",   32'(vc), 32'(got.v));
      check("cw2_detection",   32'(dc), 32'(got.dc));
      check("cw2_mismatch",    32'(mc), 32'(got.mc));
      check("cw2_pal_count",   32'(cc), 32'(got.cc));
   endtask

   vec_t vecs[$];

   initial begin
      // Hand-derived detection / mismatch_pairs for the bit-symbol configuration.
      vecs.push_back('{1, 1, 0, 8'hFF,       0, 0});
      vecs.push_back('{0, 1, 0, 8'b10100101, 1, 0});
      vecs.push_back('{0, 1, 0, 8'b11110111, 0, 1});
      vecs.push_back('{0, 1, 0, 8'b11111111, 1, 0});
      vecs.push_back('{0, 0, 0, 8'h00,       1, 0});
      vecs.push_back('{0, 0, 0, 8'h0F,       1, 0});
      vecs.push_back('{0, 0, 0, 8'h01,       1, 0});
      vecs.push_back('{0, 1, 0, 8'h01,       0, 1});
      vecs.push_back('{0, 1, 0, 8'h0F,       0, 4});
      vecs.push_back('{0, 1, 0, 8'h81,       1, 0});
      vecs.push_back('{0, 1, 0, 8'h5A,       1, 0});
      vecs.push_back('{0, 1, 0, 8'h12,       0, 2});
      vecs.push_back('{0, 1, 0, 8'h3C,       1, 0});

      foreach (vecs[k]) begin
         step(vecs[k].rst, vecs[k].iv, vecs[k].clr, vecs[k].data);
         check("table_detection", 32'(d0), 32'(vecs[k].exp_det));
         check("table_mismatch",  32'(m0), 32'(vecs[k].exp_mm));
      end

      // Nibble symbols: A5 is not a nibble palindrome, 55 is.
      step(0, 1, 0, 8'hA5);
      check("sym4_A5_detection", 32'(d4), 32'd0);
      step(0, 1, 0, 8'h55);
      check("sym4_55_detection", 32'(d4), 32'd1);

      // Saturation of the 2-bit counter, then clear coinciding with a palindrome.
      step(0, 1, 1, 8'h01);
      check("cw2_cleared", 32'(cc), 32'd0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 8'hFF);
      check("cw2_saturated", 32'(cc), 32'd3);
      step(0, 1, 1, 8'hFF);
      check("cw2_clear_and_count", 32'(cc), 32'd1);
      check("clear_and_count", 32'(c0), 32'd1);

      // Reset with a valid palindrome: dropped, everything zero.
      step(1, 1, 0, 8'hFF);
      check("rst_valid",     32'(v0), 32'd0);
      check("rst_detection", 32'(d0), 32'd0);
      check("rst_count",     32'(c0), 32'd0);
      step(0, 0, 0, 8'h00);
      check("post_rst_idle", 32'(v0), 32'd0);
      step(0, 1, 0, 8'hFF);
      check("post_rst_valid", 32'(v0), 32'd1);
      check("post_rst_count", 32'(c0), 32'd1);

      // Random words with occasional idles and clears.
      for (int i = 0; i < 40; i++) begin
         step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
              8'($urandom_range(0, 255)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/palindrome.md
# palindrome

Registered palindrome detector for a DATA_WIDTH-bit word, split into SYMBOL_WIDTH-bit symbols (bit-level by default). It sits in the datapath as a one-cycle pipelined checker. It raises `detection` when the symbol sequence of an accepted word reads the same from either end. It also keeps a saturating count of palindromic words for status readout.

## Interface
- DATA_WIDTH, 8, input word width; must be a multiple of SYMBOL_WIDTH, ≥ 1
- SYMBOL_WIDTH, 1, width of one compared symbol (1 = bit palindrome, 4 = nibble palindrome)
- COUNT_WIDTH, 16, width of palindrome counter
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  data_in is sampled this cycle
- data_in  input  DATA_WIDTH  word under test
- clear_count  input  1  synchronous clear of pal_count
- out_valid  output  1  detection is valid this cycle
- detection  output  1  1 = last accepted word is a palindrome
- mismatch_pairs  output  $clog2(N/2+1), min 1  number of mirrored symbol pairs that differ, N = DATA_WIDTH/SYMBOL_WIDTH
- pal_count  output  COUNT_WIDTH  number of palindromic words accepted since reset or clear

## Operation
- Symbol i = data_in[i*SYMBOL_WIDTH +: SYMBOL_WIDTH], i = 0..N-1.
- Pair i (0 ≤ i < N/2, integer division) compares symbol i with symbol N-1-i.
- When N is odd, the middle symbol is never compared.
- Each pair is compared as a whole symbol; symbols are not bit-reversed internally.
- mismatch_pairs = number of unequal pairs. detection = (mismatch_pairs == 0).
- N = 1 gives no pairs, so every word is a palindrome.
- When in_valid = 1, the results for data_in are registered into detection and mismatch_pairs.
- When in_valid = 0, detection and mismatch_pairs hold their last values.
- pal_count increments by 1 on each accepted word with detection true.
- pal_count saturates at 2^COUNT_WIDTH-1 and does not wrap.
- clear_count zeroes pal_count. If clear_count and a palindromic accept occur in the same cycle, the result is pal_count = 1 (clear first, then count).
- No backpressure: every in_valid cycle is accepted.

## Timing
- Latency is 1 cycle: a word sampled at edge k appears on out_valid/detection/mismatch_pairs after edge k.
- out_valid is the registered in_valid, so it is high exactly one cycle per accepted word.
- Full throughput: one word per cycle. Back-to-back words produce back-to-back results.
- pal_count reflects a word in the same cycle its out_valid is high.
- rst has priority over all inputs. On the edge where rst = 1: out_valid = 0, detection = 0, mismatch_pairs = 0, pal_count = 0.
- If in_valid is high in the same cycle as rst, that word is dropped.
- Deasserting rst mid-stream loses any word accepted in the reset cycle; normal operation resumes on the next in_valid.
- Combinational path from data_in to the register is a compare tree plus a popcount. This path must close at the target clock for DATA_WIDTH ≤ 64.

## Structure
- Shared package palindrome_pkg holds:
  - default-parameter constants (DATA_WIDTH, SYMBOL_WIDTH, COUNT_WIDTH),
  - a function computing the mismatch-count width from N.
- Sub-module palindrome_compare: purely combinational. Takes data_in and produces the per-pair mismatch vector, mismatch_pairs and the match flag.
- Top level contains the output registers, the valid pipeline and the saturating counter.
- Parameter checks (DATA_WIDTH % SYMBOL_WIDTH == 0) are elaboration-time assertions.

## Test plan
- Defaults, after reset: in_valid = 1, data_in = 8'b10100101 -> next cycle out_valid = 1, detection = 1, mismatch_pairs = 0, pal_count = 1.
- data_in = 8'b11110111 -> detection = 0, mismatch_pairs = 1, pal_count unchanged. Then 8'b11111111 -> detection = 1, pal_count increments.
- Hold in_valid = 0 for 3 cycles after a word -> out_valid = 0, detection holds its last value, pal_count is stable.
- SYMBOL_WIDTH = 4, data_in = 8'hA5 -> detection = 0. data_in = 8'h55 -> detection = 1.
- COUNT_WIDTH = 2: feed 5 palindromes -> pal_count stays at 3. Then assert clear_count with a palindrome in the same cycle -> pal_count = 1.
- Assert rst with in_valid = 1 and data_in = 8'hFF -> all outputs 0 after the edge and the word is not counted. After rst falls, the first word produces a result 1 cycle later.
